// File: rtl/pe_arb_pkg.sv
// Shared types and helpers for the PE input arbiter: FSM state encoding,
// round-robin pick function and statistics counter width.
package pe_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int STATS_CNT_WIDTH = 32;

   // First requester at or after ptr (wrapping modulo num_req) with req set.
   function automatic logic [2:0] rr_pick(
      input logic [7:0]  req,
      input logic [2:0]  ptr,
      input int unsigned num_req
   );
      logic [2:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = 3'd0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         idx = ({29'd0, ptr} + i) % num_req;
         if (!found && (i < num_req) && req[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/pe_arb_tag_fifo.sv
// Synchronous first-word fall-through FIFO holding requester tags of
// windows that are in flight through the PE.
module pe_arb_tag_fifo
   import pe_arb_pkg::*;
#(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign rd_data   = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy; a push+pop pair leaves count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/pe_input_arbiter.sv
// Round-robin arbiter sharing one PE input among NUM_REQ window generators,
// tagging accepted windows for output steering. PE_ARB_STATS_EN adds counters.
module pe_input_arbiter
   import pe_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 216,
   parameter  int TAG_DEPTH  = 8,
   localparam int TAG_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]         pe_data,
   output logic                          pe_valid,
   input  logic                          pe_ready,
   input  logic                          pe_ack,
   input  logic                          pe_o_valid,
   output logic [TAG_WIDTH-1:0]          tag_out,
   output logic                          tag_valid,
   output logic                          tag_full,
   output logic                          tag_err
`ifdef PE_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STATS_CNT_WIDTH-1:0] grant_cnt,
   output logic [STATS_CNT_WIDTH-1:0]         stall_cnt
`endif
);

   localparam int CW = $clog2(TAG_DEPTH) + 1;

   arb_state_t            state_r;
   arb_state_t            state_next_s;
   logic [TAG_WIDTH-1:0]  grant_r;
   logic [TAG_WIDTH-1:0]  rr_ptr_r;
   logic [TAG_WIDTH-1:0]  pick_s;
   logic [DATA_WIDTH-1:0] pe_data_r;
   logic [DATA_WIDTH-1:0] win_data_s;
   logic                  grant_start_s;
   logic                  accept_s;
   logic                  room_s;
   logic                  fifo_empty_s;
   logic                  fifo_full_s;
   logic [CW-1:0]         fifo_count_s;
   logic                  tag_err_r;

   assign pick_s     = TAG_WIDTH'(rr_pick(8'(req_valid), 3'(rr_ptr_r), unsigned'(NUM_REQ)));
   assign win_data_s = req_data[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
   assign room_s     = (fifo_count_s != CW'(TAG_DEPTH));

   // Next-state: leave IDLE only when a tag slot is free and the PE is ready.
   always_comb begin
      state_next_s  = state_r;
      grant_start_s = 1'b0;
      accept_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if ((|req_valid) && room_s && pe_ready) begin
               state_next_s  = GRANT;
               grant_start_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         GRANT: begin
            if (pe_ack) begin
               state_next_s = IDLE;
               accept_s     = 1'b1;
            end else begin
               state_next_s = GRANT;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State, locked grant, captured window and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         grant_r   <= {TAG_WIDTH{1'b0}};
         rr_ptr_r  <= {TAG_WIDTH{1'b0}};
         pe_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (grant_start_s) begin
            grant_r   <= pick_s;
            pe_data_r <= win_data_s;
         end
         if (accept_s) begin
            rr_ptr_r <= (grant_r == TAG_WIDTH'(NUM_REQ - 1)) ? {TAG_WIDTH{1'b0}}
                                                             : grant_r + TAG_WIDTH'(1);
         end
      end
   end

   // Acceptance pulse back to the granted requester, same cycle as pe_ack.
   always_comb begin
      req_ack = {NUM_REQ{1'b0}};
      if (accept_s) begin
         req_ack[grant_r] = 1'b1;
      end else begin
         req_ack = {NUM_REQ{1'b0}};
      end
   end

   assign pe_valid = (state_r == GRANT);
   assign pe_data  = pe_data_r;

   pe_arb_tag_fifo #(
      .WIDTH (TAG_WIDTH),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept_s),
      .pop     (pe_o_valid),
      .wr_data (grant_r),
      .rd_data (tag_out),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   assign tag_valid = pe_o_valid & ~fifo_empty_s;
   assign tag_full  = fifo_full_s;
   assign tag_err   = tag_err_r;

   // Sticky flag: a PE output beat with no tag outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_err_r <= 1'b0;
      end else if (pe_o_valid && fifo_empty_s) begin
         tag_err_r <= 1'b1;
      end else begin
         tag_err_r <= tag_err_r;
      end
   end

`ifdef PE_ARB_STATS_EN
   logic [STATS_CNT_WIDTH-1:0] grant_cnt_r [NUM_REQ];
   logic [STATS_CNT_WIDTH-1:0] stall_cnt_r;
   logic                       stall_s;

   assign stall_s = (state_r == IDLE) && (|req_valid) && (!room_s || !pe_ready);

   // Saturating per-requester acceptance counts and blocked-grant cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            grant_cnt_r[r] <= {STATS_CNT_WIDTH{1'b0}};
         end
         stall_cnt_r <= {STATS_CNT_WIDTH{1'b0}};
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ack[r] && (grant_cnt_r[r] != {STATS_CNT_WIDTH{1'b1}})) begin
               grant_cnt_r[r] <= grant_cnt_r[r] + STATS_CNT_WIDTH'(1);
            end
         end
         if (stall_s && (stall_cnt_r != {STATS_CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STATS_CNT_WIDTH'(1);
         end
      end
   end

   // Flatten the per-requester counters onto the output bus.
   always_comb begin
      grant_cnt = {(NUM_REQ*STATS_CNT_WIDTH){1'b0}};
      for (int r = 0; r < NUM_REQ; r++) begin
         grant_cnt[r*STATS_CNT_WIDTH +: STATS_CNT_WIDTH] = grant_cnt_r[r];
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pe_input_arbiter.sv
// Self-checking bench for pe_input_arbiter: directed scenarios plus a random
// phase, checked against a transaction-level model with a tag queue.
module tb_pe_input_arbiter;

   localparam int N     = 4;
   localparam int DW    = 216;
   localparam int DEPTH = 8;
   localparam int TW    = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ack;
   logic [DW-1:0]   pe_data;
   logic            pe_valid;
   logic            pe_ready;
   logic            pe_ack;
   logic            pe_o_valid;
   logic [TW-1:0]   tag_out;
   logic            tag_valid;
   logic            tag_full;
   logic            tag_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_ptr;
   bit            m_busy;
   int            m_g;
   logic [DW-1:0] m_data;
   bit            m_err;
   int            tagq[$];
   int            grants[$];
   int            last_ack;

   pe_input_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data   (req_data),
      .req_valid  (req_valid),
      .req_ack    (req_ack),
      .pe_data    (pe_data),
      .pe_valid   (pe_valid),
      .pe_ready   (pe_ready),
      .pe_ack     (pe_ack),
      .pe_o_valid (pe_o_valid),
      .tag_out    (tag_out),
      .tag_valid  (tag_valid),
      .tag_full   (tag_full),
      .tag_err    (tag_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_data();
      for (int k = 0; k < (N*DW)/32; k++) begin
         req_data[k*32 +: 32] = $urandom();
      end
   endtask

   task automatic model_clear();
      m_ptr  = 0;
      m_busy = 1'b0;
      m_g    = 0;
      m_err  = 1'b0;
      tagq.delete();
      grants.delete();
   endtask

   // One clock cycle: check outputs against the model, advance the model, clock.
   task automatic step();
      logic [N-1:0] exp_ack;
      int           sz;
      #1;
      exp_ack  = '0;
      last_ack = -1;
      if (m_busy && pe_ack) begin
         exp_ack[m_g] = 1'b1;
         last_ack     = m_g;
      end
      chk("req_ack", DW'(req_ack), DW'(exp_ack));
      chk("pe_valid", DW'(pe_valid), DW'(m_busy));
      if (m_busy) chk("pe_data", pe_data, m_data);
      chk("tag_valid", DW'(tag_valid), DW'(pe_o_valid && (tagq.size() > 0)));
      if (tagq.size() > 0) chk("tag_out", DW'(tag_out), DW'(tagq[0]));
      chk("tag_full", DW'(tag_full), DW'(tagq.size() == DEPTH));
      chk("tag_err", DW'(tag_err), DW'(m_err));
      sz = tagq.size();
      if (pe_o_valid) begin
         if (sz > 0) tagq.delete(0);
         else m_err = 1'b1;
      end
      if (m_busy) begin
         if (pe_ack) begin
            tagq.push_back(m_g);
            grants.push_back(m_g);
            m_ptr  = (m_g + 1) % N;
            m_busy = 1'b0;
         end
      end else if ((req_valid != '0) && (sz < DEPTH) && pe_ready) begin
         for (int i = 0; i < N; i++) begin
            if (!m_busy && req_valid[(m_ptr + i) % N]) begin
               m_g    = (m_ptr + i) % N;
               m_busy = 1'b1;
            end
         end
         m_data = req_data[m_g*DW +: DW];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = '0;
      pe_ack     = 1'b0;
      pe_o_valid = 1'b0;
      pe_ready   = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_pe_valid", DW'(pe_valid), DW'(0));
      chk("rst_req_ack", DW'(req_ack), DW'(0));
      chk("rst_pe_data", pe_data, DW'(0));
      chk("rst_tag_out", DW'(tag_out), DW'(0));
      chk("rst_tag_valid", DW'(tag_valid), DW'(0));
      chk("rst_tag_full", DW'(tag_full), DW'(0));
      chk("rst_tag_err", DW'(tag_err), DW'(0));
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      int cnt[N];
      int vc;
      bit pv;
      req_data = '0;
      model_clear();

      // single requester, PE acks three cycles after pe_valid
      do_reset();
      rand_data();
      req_valid = 4'b0100;
      step();
      chk("s1_data", pe_data, req_data[2*DW +: DW]);
      repeat (3) step();
      pe_ack = 1'b1;
      #1;
      chk("s1_ack", DW'(req_ack), DW'(4'b0100));
      step();
      req_valid = '0;
      pe_ack    = 1'b0;
      step();
      pe_o_valid = 1'b1;
      #1;
      chk("s1_tag", DW'(tag_out), DW'(2));
      chk("s1_tag_valid", DW'(tag_valid), DW'(1));
      step();
      pe_o_valid = 1'b0;

      // all four requesting, ack one cycle after pe_valid
      do_reset();
      rand_data();
      req_valid = 4'hF;
      vc = 0;
      for (int c = 0; c < 200 && grants.size() < 16; c++) begin
         pe_ack     = pe_valid && (vc >= 1);
         pe_o_valid = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
         pv         = pe_valid;
         step();
         vc = (pv && !pe_ack) ? vc + 1 : 0;
         rand_data();
      end
      pe_ack     = 1'b0;
      pe_o_valid = 1'b0;
      chk("s2_ngrants", DW'(grants.size()), DW'(16));
      for (int r = 0; r < N; r++) cnt[r] = 0;
      for (int i = 0; i < grants.size(); i++) begin
         chk("s2_order", DW'(grants[i]), DW'(i % 4));
         cnt[grants[i]]++;
      end
      for (int r = 0; r < N; r++) chk("s2_count", DW'(cnt[r]), DW'(4));

      // tag FIFO fills: exactly 8 grants, then one pop releases the 9th
      do_reset();
      rand_data();
      req_valid = 4'hF;
      for (int c = 0; c < 40; c++) begin
         pe_ack = pe_valid;
         step();
      end
      chk("s3_ngrants", DW'(grants.size()), DW'(8));
      chk("s3_stalled", DW'(pe_valid), DW'(0));
      chk("s3_full", DW'(tag_full), DW'(1));
      pe_ack     = 1'b0;
      pe_o_valid = 1'b1;
      chk("s3_head", DW'(tag_out), DW'(0));
      step();
      pe_o_valid = 1'b0;
      chk("s3_wait", DW'(pe_valid), DW'(0));
      step();
      chk("s3_ninth", DW'(pe_valid), DW'(1));
      pe_ack = 1'b1;
      step();
      pe_ack = 1'b0;

      // push and pop together with a single tag queued
      do_reset();
      rand_data();
      req_valid = 4'b0011;
      step();
      pe_ack = 1'b1;
      step();
      req_valid = 4'b0010;
      pe_ack    = 1'b0;
      step();
      pe_ack     = 1'b1;
      pe_o_valid = 1'b1;
      chk("s4_head0", DW'(tag_out), DW'(0));
      step();
      req_valid  = '0;
      pe_ack     = 1'b0;
      pe_o_valid = 1'b0;
      step();
      pe_o_valid = 1'b1;
      chk("s4_head1", DW'(tag_out), DW'(1));
      step();
      pe_o_valid = 1'b0;

      // spurious PE output with nothing in flight
      do_reset();
      pe_o_valid = 1'b1;
      #1;
      chk("s5_tag_valid", DW'(tag_valid), DW'(0));
      step();
      pe_o_valid = 1'b0;
      chk("s5_err", DW'(tag_err), DW'(1));
      repeat (3) step();
      chk("s5_err_held", DW'(tag_err), DW'(1));

      // reset while granted with three tags queued
      do_reset();
      rand_data();
      req_valid = 4'hF;
      for (int c = 0; c < 60; c++) begin
         if (grants.size() == 3 && pe_valid) break;
         pe_ack = pe_valid && (grants.size() < 3);
         step();
      end
      chk("s6_queued", DW'(grants.size()), DW'(3));
      chk("s6_in_grant", DW'(pe_valid), DW'(1));
      pe_ack = 1'b1;
      rst    = 1'b1;
      #1;
      chk("s6_rst_valid", DW'(pe_valid), DW'(0));
      chk("s6_rst_ack", DW'(req_ack), DW'(0));
      chk("s6_rst_full", DW'(tag_full), DW'(0));
      pe_o_valid = 1'b1;
      #1;
      chk("s6_rst_empty", DW'(tag_valid), DW'(0));
      pe_o_valid = 1'b0;
      pe_ack     = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      step();
      chk("s6_first_valid", DW'(pe_valid), DW'(1));
      chk("s6_first_data", pe_data, req_data[0 +: DW]);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rand_data();
         req_valid  = req_valid | N'($urandom_range(0, 15) & $urandom_range(0, 15));
         pe_ready   = ($urandom_range(0, 3) != 0);
         pe_ack     = pe_valid && ($urandom_range(0, 2) == 0);
         pe_o_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
         step();
         if (last_ack >= 0) req_valid[last_ack] = 1'b0;
      end
      chk("rnd_progress", DW'(grants.size() > 50), DW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_input_arbiter.md
Name: pe_input_arbiter

Overview:
- Shares one convolution PE input port between NUM_REQ window-generator requesters using round-robin arbitration.
- Follows the PE's ready/valid/ack handshake on the PE side.
- Records the requester index of every accepted window in a tag FIFO, so each PE output beat can be steered back to the correct consumer.
- Sits between the line-buffer/window stage and the PE; the PE itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 216, flattened window width (8 * IN_CHANNEL * KERNEL_PTS).
- TAG_DEPTH, 8, in-flight tag FIFO depth (power of 2, >= 2).
- TAG_WIDTH, $clog2(NUM_REQ), derived localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_data  in  NUM_REQ*DATA_WIDTH  requester windows; slice r belongs to requester r.
- req_valid  in  NUM_REQ  request pending per requester; held until req_ack.
- req_ack  out  NUM_REQ  one-hot one-cycle acceptance pulse.
- pe_data  out  DATA_WIDTH  window to PE i_data.
- pe_valid  out  1  to PE i_valid.
- pe_ready  in  1  from PE.
- pe_ack  in  1  from PE; the window is latched by the PE this cycle.
- pe_o_valid  in  1  PE o_valid; one pulse per accepted window, in order.
- tag_out  out  TAG_WIDTH  requester index of the current PE output.
- tag_valid  out  1  tag_out qualifier; equals pe_o_valid when the FIFO is non-empty.
- tag_full  out  1  tag FIFO full.
- tag_err  out  1  sticky error flag: pe_o_valid arrived while the FIFO was empty.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr=0, FIFO empty, tag_err=0.
- A reset mid-transaction drops the grant and all tags; the system-level reset also resets the PE.
- Grant search is round-robin: start at rr_ptr and select the first r with req_valid[r]=1, scanning in wrapping order.
- IDLE -> GRANT when any req_valid=1 and tag_full=0 and pe_ready=1. Register grant index g and register pe_data=req_data[g]. pe_valid=1 from the next cycle.
- In GRANT, pe_data is held and pe_valid=1 until pe_ack=1.
- On pe_ack in GRANT:
  - req_ack[g]=1 in the same cycle (combinational from pe_ack & state).
  - push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - next state IDLE; pe_valid drops the following cycle.
- Minimum spacing between grants is 2 cycles, which matches the PE controller's ack pacing.
- The grant is locked: a deassertion of req_valid[g] while in GRANT is ignored. Requesters must hold their request until ack.
- pe_ack while in IDLE is ignored.
- Tag FIFO behaviour:
  - Pop on pe_o_valid. tag_out is the FIFO head, combinational (first-word fall-through).
  - Simultaneous push and pop: count is unchanged; data is correct even when count=1.
  - Full: no new grant leaves IDLE. A push cannot overflow because a grant requires tag_full=0 at entry.
  - Empty with pe_o_valid=1: tag_valid=0, tag_err latches 1, no pop.
- Latency:
  - req_valid to pe_valid: 1 cycle.
  - pe_ack to req_ack: 0 cycles.
  - push to tag visible at head: 1 cycle.

Optional Feature:
- Macro: PE_ARB_STATS_EN.
- When defined, adds two outputs:
  - grant_cnt, NUM_REQ*32 bits: per-requester saturating counts of req_ack pulses.
  - stall_cnt, 32 bits, saturating: cycles where any req_valid=1 while in IDLE but the grant is blocked by tag_full or !pe_ready.
  - Both counters are cleared by rst.
- When undefined, these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package pe_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - the function rr_pick(req, ptr) returning the index;
  - the STATS_CNT_WIDTH=32 constant.
- Sub-module pe_arb_tag_fifo: parameterized synchronous FIFO (TAG_WIDTH x TAG_DEPTH) with first-word fall-through, full/empty flags and count.

Test Plan:
- Single requester: req_valid=4'b0100; PE acks 3 cycles after pe_valid -> pe_data equals slice 2; req_ack=4'b0100 for exactly one cycle; after PE output, tag_out=2 with tag_valid=1.
- All four requesting continuously, PE always ready, PE acks one cycle after pe_valid -> grant order 0,1,2,3,0,1...; each requester receives exactly 4 acks over 16 grants.
- tag_full: TAG_DEPTH=8 and PE outputs withheld -> exactly 8 grants, then pe_valid stays 0 and tag_full=1. One pe_o_valid pulse -> tag_out=0 popped and the 9th grant issues 2 cycles later.
- Simultaneous push/pop with count=1: the 2nd grant's ack coincides with the 1st output -> tag_out=0 on that cycle, tag_out=1 on the next output.
- Spurious pe_o_valid with the FIFO empty -> tag_valid=0, tag_err=1 and held until rst.
- rst asserted while in GRANT with 3 tags queued -> next cycle pe_valid=0, req_ack=0, FIFO empty, rr_ptr=0. After release, requester 0 wins first when all four are requesting.
